// File: rtl/ppu_pkg.sv
// Shared types and helpers for the PPU background fetch path.
package ppu_pkg;

    localparam int TB_AW = 10;
    localparam int TG_AW = 11;

    // One tile-map word as stored in the tile buffer (bits [15:13] unused).
    typedef struct packed {
        logic       vflip;
        logic       hflip;
        logic [2:0] pal;
        logic [7:0] index;
    } tile_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAP,
        S_GFX,
        S_CAP,
        S_OUT
    } fetch_state_t;

    // Mirror a pattern byte so the leftmost pixel moves to the right edge.
    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bg_tile_fetcher.sv
// Background scanline fetcher: per line, walks the tile-map row, fetches the
// matching 2bpp pattern row for each tile, applies flips and hands each 8-pixel
// slice plus palette to the shift-register block over valid/ready.
module bg_tile_fetcher
    import ppu_pkg::*;
#(
    parameter int unsigned TILES_PER_ROW = 32,
    parameter int unsigned VISIBLE_LINES = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  line,
    output logic [9:0]  tb_addr,
    input  logic [15:0] tb_data,
    output logic [10:0] tg_addr,
    input  logic [15:0] tg_data,
    output logic [7:0]  out_lo,
    output logic [7:0]  out_hi,
    output logic [2:0]  out_pal,
    output logic [4:0]  out_col,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam int         COL_W    = $clog2(TILES_PER_ROW);
    localparam logic [4:0] LAST_COL = 5'(TILES_PER_ROW - 1);

    fetch_state_t state, next_state;

    logic [4:0]  map_row;
    logic [2:0]  fine_y;
    logic [4:0]  col;
    tile_entry_t entry;

    tile_entry_t      map_word;
    logic [2:0]       fy;
    logic [TB_AW-1:0] row_base;
    logic             accept;
    logic             last_col;
    logic             unused_bits;

    assign map_word    = tile_entry_t'(tb_data[12:0]);
    assign fy          = map_word.vflip ? (3'd7 - fine_y) : fine_y;
    assign row_base    = TB_AW'(map_row) << COL_W;
    assign accept      = (state == S_IDLE) && start && (32'(line) < VISIBLE_LINES);
    assign last_col    = (col == LAST_COL);
    assign unused_bits = ^tb_data[15:13];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: one tile walks MAP -> GFX -> CAP -> OUT.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_MAP;
            S_MAP:   next_state = S_GFX;
            S_GFX:   next_state = S_CAP;
            S_CAP:   next_state = S_OUT;
            S_OUT:   if (out_ready) next_state = last_col ? S_IDLE : S_MAP;
            default: next_state = S_IDLE;
        endcase
    end

    // Memory addresses: tile-map address in S_MAP; in S_GFX the map word is
    // on tb_data already, so the pattern address is formed from it directly.
    always_comb begin
        tb_addr = '0;
        tg_addr = '0;
        if (state == S_MAP) begin
            tb_addr = row_base + TB_AW'(col);
        end
        if (state == S_GFX) begin
            tg_addr = {map_word.index, fy};
        end
    end

    // Line context, tile entry and registered slice outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            map_row   <= '0;
            fine_y    <= '0;
            col       <= '0;
            entry     <= '0;
            out_lo    <= '0;
            out_hi    <= '0;
            out_pal   <= '0;
            out_col   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        map_row <= line[7:3];
                        fine_y  <= line[2:0];
                        col     <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_GFX: begin
                    entry <= map_word;
                end
                S_CAP: begin
                    out_hi    <= entry.hflip ? bitrev8(tg_data[15:8]) : tg_data[15:8];
                    out_lo    <= entry.hflip ? bitrev8(tg_data[7:0])  : tg_data[7:0];
                    out_pal   <= entry.pal;
                    out_col   <= col;
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_col) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            col <= col + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Directed bench for bg_tile_fetcher with behavioural tile buffer / graphics RAMs.
module tb_bg_tile_fetcher;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  line;
    logic [9:0]  tb_addr;
    logic [15:0] tb_data;
    logic [10:0] tg_addr;
    logic [15:0] tg_data;
    logic [7:0]  out_lo;
    logic [7:0]  out_hi;
    logic [2:0]  out_pal;
    logic [4:0]  out_col;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic [15:0] tb_mem [1024];
    logic [15:0] tg_mem [2048];

    int checks = 0;
    int errors = 0;

    bg_tile_fetcher #(.TILES_PER_ROW(32), .VISIBLE_LINES(240)) dut (
        .clk(clk), .reset(reset), .start(start), .line(line),
        .tb_addr(tb_addr), .tb_data(tb_data),
        .tg_addr(tg_addr), .tg_data(tg_data),
        .out_lo(out_lo), .out_hi(out_hi), .out_pal(out_pal), .out_col(out_col),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle synchronous read memories.
    always @(posedge clk) begin
        tb_data <= tb_mem[tb_addr];
        tg_data <= tg_mem[tg_addr];
    end

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) tb_mem[i] = 16'h0000;
        for (int i = 0; i < 2048; i++) tg_mem[i] = 16'h0000;
    endtask

    // Pulse start for one edge; returns #1 after that edge (first S_MAP cycle).
    task automatic do_start(input logic [7:0] l);
        @(negedge clk);
        start = 1'b1;
        line  = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({tb_addr, tg_addr, out_lo, out_hi, out_pal, out_col, out_valid, busy, done} !== 50'd0) begin
            errors++;
            $display("FAIL reset_outputs got tb=%h tg=%h lo=%h hi=%h pal=%h col=%h v=%b busy=%b done=%b required all 0",
                     tb_addr, tg_addr, out_lo, out_hi, out_pal, out_col, out_valid, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_line0();
        int n = 0;
        int slices = 0;
        bit seen_done = 0;
        clear_mem();
        tg_mem[0] = 16'hF00F;
        out_ready = 1'b1;
        do_start(8'd0);
        while (n < 400) begin
            if (out_valid) begin
                if (slices == 0) begin
                    checks++;
                    if (n !== 3) begin
                        errors++;
                        $display("FAIL line0_first_valid got cycle %0d required 3", n);
                    end
                end
                checks++;
                if (out_hi !== 8'hF0 || out_lo !== 8'h0F || out_pal !== 3'd0 || out_col !== 5'(slices)) begin
                    errors++;
                    $display("FAIL line0_slice got hi=%h lo=%h pal=%0d col=%0d required hi=f0 lo=0f pal=0 col=%0d",
                             out_hi, out_lo, out_pal, out_col, slices);
                end
                slices++;
            end
            if (done) begin
                seen_done = 1;
                break;
            end
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!seen_done || n !== 128) begin
            errors++;
            $display("FAIL line0_done_time got %0d (seen=%0d) required 128", n, seen_done);
        end
        checks++;
        if (slices !== 32) begin
            errors++;
            $display("FAIL line0_slice_count got %0d required 32", slices);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL line0_busy_with_done got %b required 0", busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL line0_done_pulse got %b required 0", done);
        end
    endtask

    task automatic test_hflip();
        int n = 0;
        bit seen_done = 0;
        bit seen_col1 = 0;
        clear_mem();
        tb_mem[33] = 16'h0D05;
        tg_mem[11'h02D] = 16'h8001;
        out_ready = 1'b1;
        do_start(8'd13);
        while (n < 400) begin
            if (n == 4) begin
                checks++;
                if (tb_addr !== 10'd33) begin
                    errors++;
                    $display("FAIL hflip_tb_addr got %0d required 33", tb_addr);
                end
            end
            if (n == 5) begin
                checks++;
                if (tg_addr !== 11'h02D) begin
                    errors++;
                    $display("FAIL hflip_tg_addr got %h required 02d", tg_addr);
                end
            end
            if (out_valid && out_col == 5'd1 && !seen_col1) begin
                seen_col1 = 1;
                checks++;
                if (out_hi !== 8'h01 || out_lo !== 8'h80 || out_pal !== 3'd5) begin
                    errors++;
                    $display("FAIL hflip_slice got hi=%h lo=%h pal=%0d required hi=01 lo=80 pal=5",
                             out_hi, out_lo, out_pal);
                end
            end
            if (done) begin
                seen_done = 1;
                break;
            end
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!seen_done || !seen_col1) begin
            errors++;
            $display("FAIL hflip_complete got done=%0d col1=%0d required 1 1", seen_done, seen_col1);
        end
    endtask

    task automatic test_vflip();
        int n = 0;
        bit seen_done = 0;
        clear_mem();
        tb_mem[0] = 16'h1007;
        out_ready = 1'b1;
        do_start(8'd2);
        while (n < 400) begin
            if (n == 1) begin
                checks++;
                if (tg_addr !== 11'h03D) begin
                    errors++;
                    $display("FAIL vflip_tg_addr got %h required 03d", tg_addr);
                end
            end
            if (done) begin
                seen_done = 1;
                break;
            end
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL vflip_done got timeout required done");
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        bit seen_done = 0;
        bit stalled = 0;
        logic [23:0] held;
        clear_mem();
        tb_mem[3] = 16'h0203;
        tg_mem[8'd3 * 8] = 16'hA55A;
        out_ready = 1'b1;
        do_start(8'd0);
        while (n < 400) begin
            if (out_valid && out_col == 5'd3 && !stalled) begin
                stalled = 1;
                held = {out_hi, out_lo, out_pal, out_col};
                checks++;
                if (held !== {8'hA5, 8'h5A, 3'd2, 5'd3}) begin
                    errors++;
                    $display("FAIL stall_slice got %h required %h", held, {8'hA5, 8'h5A, 3'd2, 5'd3});
                end
                out_ready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk); #1; n++;
                    checks++;
                    if (out_valid !== 1'b1 || {out_hi, out_lo, out_pal, out_col} !== held) begin
                        errors++;
                        $display("FAIL stall_hold got v=%b data=%h required v=1 data=%h",
                                 out_valid, {out_hi, out_lo, out_pal, out_col}, held);
                    end
                end
                out_ready = 1'b1;
            end
            if (done) begin
                seen_done = 1;
                break;
            end
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!seen_done || n !== 138) begin
            errors++;
            $display("FAIL stall_line_time got %0d (seen=%0d) required 138", n, seen_done);
        end
    endtask

    task automatic test_bad_line();
        do_start(8'd240);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || tb_addr !== 10'd0) begin
                errors++;
                $display("FAIL bad_line got busy=%b done=%b v=%b tb=%0d required 0 0 0 0",
                         busy, done, out_valid, tb_addr);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_while_busy();
        int n = 0;
        int slices = 0;
        bit seen_done = 0;
        clear_mem();
        for (int i = 32; i < 64; i++) tb_mem[i] = 16'h0700;
        out_ready = 1'b1;
        do_start(8'd0);
        while (n < 400) begin
            if (n == 10) begin
                start = 1'b1;
                line  = 8'd8;
            end
            if (n == 11) start = 1'b0;
            if (out_valid) begin
                checks++;
                if (out_pal !== 3'd0 || out_col !== 5'(slices)) begin
                    errors++;
                    $display("FAIL busy_start_slice got pal=%0d col=%0d required pal=0 col=%0d",
                             out_pal, out_col, slices);
                end
                slices++;
            end
            if (done) begin
                seen_done = 1;
                break;
            end
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!seen_done || n !== 128 || slices !== 32) begin
            errors++;
            $display("FAIL busy_start_line got cycles=%0d slices=%0d required 128 32", n, slices);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle got busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit seen_done = 0;
        bit first = 1;
        clear_mem();
        tb_mem[7] = 16'h0009;
        out_ready = 1'b1;
        do_start(8'd0);
        while (n < 29) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (tg_addr !== 11'h048) begin
            errors++;
            $display("FAIL mid_gfx_tile7 got tg=%h required 048", tg_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({tb_addr, tg_addr, out_lo, out_hi, out_pal, out_col, out_valid, busy, done} !== 50'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got tb=%h tg=%h lo=%h hi=%h pal=%h col=%h v=%b busy=%b done=%b required all 0",
                     tb_addr, tg_addr, out_lo, out_hi, out_pal, out_col, out_valid, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        do_start(8'd8);
        n = 0;
        checks++;
        if (tb_addr !== 10'd32) begin
            errors++;
            $display("FAIL restart_tb_addr got %0d required 32", tb_addr);
        end
        while (n < 400) begin
            if (out_valid && first) begin
                first = 0;
                checks++;
                if (out_col !== 5'd0 || n !== 3) begin
                    errors++;
                    $display("FAIL restart_first_col got col=%0d cycle=%0d required col=0 cycle=3", out_col, n);
                end
            end
            if (done) begin
                seen_done = 1;
                break;
            end
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!seen_done || n !== 128) begin
            errors++;
            $display("FAIL restart_done got %0d (seen=%0d) required 128", n, seen_done);
        end
    endtask

    initial begin
        start     = 1'b0;
        line      = 8'd0;
        out_ready = 1'b1;
        reset     = 1'b1;
        clear_mem();
        test_reset();
        test_line0();
        test_hflip();
        test_vflip();
        test_backpressure();
        test_bad_line();
        test_start_while_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
